// File: rtl/result_matrix_collector_if.sv
// Port bundle of the result matrix collector: the multiplier result
// handshake, the drain stream and the clear/status lines.
interface result_matrix_collector_if #(
    parameter int M_LEN = 2,
    parameter int W     = 32
);
    logic             clear;
    logic [W-1:0]     z_in;
    logic [M_LEN-1:0] z_i;
    logic [M_LEN-1:0] z_j;
    logic             z_stb;
    logic             z_ack;
    logic [W-1:0]     current_element;
    logic             mm_done;
    logic [W-1:0]     out_data;
    logic [M_LEN-1:0] out_i;
    logic [M_LEN-1:0] out_j;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             drain_done;
    logic             idx_err;

    modport master (
        output clear, z_in, z_i, z_j, z_stb, mm_done, out_ready,
        input  z_ack, current_element, out_data, out_i, out_j,
               out_valid, out_last, drain_done, idx_err
    );

    modport slave (
        input  clear, z_in, z_i, z_j, z_stb, mm_done, out_ready,
        output z_ack, current_element, out_data, out_i, out_j,
               out_valid, out_last, drain_done, idx_err
    );
endinterface

// File: rtl/result_matrix_collector.sv
// Collects multiplier results into an MxM store and streams the finished
// matrix row-major once the multiplier signals completion.
module result_matrix_collector #(
    parameter int M     = 4,
    parameter int M_LEN = 2,
    parameter int W     = 32
) (
    input logic                  clk,
    input logic                  rst,
    result_matrix_collector_if.slave bus
);
    typedef enum logic [1:0] {COLLECT, ACK, DRAIN} state_t;

    localparam logic [M_LEN-1:0] LAST_IDX = M_LEN'(M - 1);

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     store [M][M];
    logic             done_pend;
    logic             in_range;
    logic             write_en;
    logic             pend_set;
    logic             start_drain;
    logic             beat_take;
    logic             last_beat;
    logic [M_LEN-1:0] next_i;
    logic [M_LEN-1:0] next_j;

    assign in_range = (int'(bus.z_i) < M) && (int'(bus.z_j) < M);
    assign bus.current_element = in_range ? store[bus.z_i][bus.z_j] : '0;

    always_comb begin
        state_next  = state;
        write_en    = 1'b0;
        pend_set    = 1'b0;
        start_drain = 1'b0;
        beat_take   = 1'b0;
        last_beat   = (bus.out_i == LAST_IDX) && (bus.out_j == LAST_IDX);
        next_i      = bus.out_i;
        next_j      = bus.out_j;
        if (bus.out_j == LAST_IDX) begin
            next_j = '0;
            next_i = bus.out_i + M_LEN'(1);
        end else begin
            next_j = bus.out_j + M_LEN'(1);
        end

        case (state)
            COLLECT: begin
                if (bus.z_stb) begin
                    write_en   = 1'b1;
                    pend_set   = bus.mm_done;
                    state_next = ACK;
                end else if (bus.mm_done || done_pend) begin
                    start_drain = 1'b1;
                    state_next  = DRAIN;
                end
            end
            ACK: begin
                pend_set   = bus.mm_done;
                state_next = COLLECT;
            end
            DRAIN: begin
                if (bus.out_valid && bus.out_ready) begin
                    beat_take = 1'b1;
                    if (last_beat) begin
                        state_next = COLLECT;
                    end
                end
            end
            default: state_next = COLLECT;
        endcase

        // clear overrides every action, including a strobe offered that cycle
        if (bus.clear) begin
            state_next  = COLLECT;
            write_en    = 1'b0;
            pend_set    = 1'b0;
            start_drain = 1'b0;
            beat_take   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.clear) begin
            for (int a = 0; a < M; a++) begin
                for (int b = 0; b < M; b++) begin
                    store[a][b] <= '0;
                end
            end
            done_pend      <= 1'b0;
            bus.z_ack      <= 1'b0;
            bus.idx_err    <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.drain_done <= 1'b0;
            bus.out_data   <= '0;
            bus.out_i      <= '0;
            bus.out_j      <= '0;
        end else begin
            bus.z_ack      <= write_en;
            bus.drain_done <= 1'b0;

            if (write_en) begin
                if (in_range) begin
                    store[bus.z_i][bus.z_j] <= bus.z_in;
                end else begin
                    bus.idx_err <= 1'b1;
                end
            end

            if (pend_set) begin
                done_pend <= 1'b1;
            end

            if (start_drain) begin
                done_pend     <= 1'b0;
                bus.out_valid <= 1'b1;
                bus.out_i     <= '0;
                bus.out_j     <= '0;
                bus.out_data  <= store[0][0];
                bus.out_last  <= (M == 1);
            end

            // the stream registers only move when a beat is accepted
            if (beat_take) begin
                if (last_beat) begin
                    bus.out_valid  <= 1'b0;
                    bus.out_last   <= 1'b0;
                    bus.drain_done <= 1'b1;
                end else begin
                    bus.out_i    <= next_i;
                    bus.out_j    <= next_j;
                    bus.out_data <= store[next_i][next_j];
                    bus.out_last <= (next_i == LAST_IDX) && (next_j == LAST_IDX);
                end
            end
        end
    end
endmodule
